jtdsp16_rom_loader: RTL and testbench
=====================================

Name: jtdsp16_rom_loader

Overview:
- Sequences programming of the DSP16 internal program ROM (8 KB, byte-programmed, 4K×16) from a host byte stream.
- Holds the DSP core in reset while programming, since the ROM programming port is only valid under reset.
- Drives the ROM's prog_addr/prog_data/prog_we interface and keeps a running byte checksum.
- Releases the core after a programmable reset-hold delay.
- Sits between the system download logic and the ROM/core in the jtdsp16 top level.

Parameters:
- RST_HOLD, 16: clk cycles dsp_rst stays high after the last programming write before release (≥1).
- CW, 5: width of the hold counter; must satisfy 2^CW > RST_HOLD.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- dl_len  in  13  bytes to load, sampled on start; 0 means 8192.
- dl_data  in  8  host byte.
- dl_valid  in  1  host byte valid.
- dl_ready  out  1  loader accepts dl_data this cycle.
- prog_addr  out  13  ROM byte address; even = LSB, odd = MSB of word addr[12:1].
- prog_data  out  8  ROM write data.
- prog_we  out  1  ROM write strobe.
- dsp_rst  out  1  core reset, active high.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when dsp_rst falls.
- cks  out  16  mod-2^16 sum of loaded bytes.
- pt  out  12  ROM word read address (verify feature only; otherwise 0).
- pt_dout  in  16  ROM read data, one-cycle latency (verify feature only).
- vfy_err  out  1  verify mismatch flag (verify feature only; otherwise 0).

Behaviour:
- Reset values:
  - state = IDLE, dsp_rst = 1, dl_ready = 0, prog_we = 0.
  - prog_addr = 0, prog_data = 0.
  - busy = 0, done = 0, cks = 0, pt = 0, vfy_err = 0.
- Reset mid-load aborts the load. The ROM keeps any partial contents and the core stays in reset.
- FSM states: IDLE, LOAD, VERIFY (feature only), HOLD.
- IDLE:
  - On start: latch dl_len, clear the byte counter and cks, set dsp_rst = 1 and busy = 1, then go to LOAD.
  - start is ignored in every other state.
- LOAD:
  - dl_ready = 1 while remaining byte count > 0.
  - A byte is accepted on an edge where dl_valid & dl_ready.
  - In the following cycle: prog_we = 1, prog_addr = index of the accepted byte, prog_data = that byte, cks += byte.
  - Throughput is one byte per cycle; dl_valid gaps insert idle cycles with prog_we = 0.
  - After the last byte is accepted, dl_ready drops in the same cycle the final prog_we is issued. Extra host bytes are never accepted.
  - The next state (VERIFY or HOLD) is entered the cycle after the final prog_we.
- Address wrap: dl_len = 0 loads addresses 0..8191. The counter is 13 bits and never wraps within a load.
- HOLD:
  - Count RST_HOLD cycles, then set dsp_rst = 0 and busy = 0, pulse done for one cycle, and return to IDLE.
  - dsp_rst remains 0 until the next start.
- A new load restarts from address 0 and does not preserve prior contents.
- prog_we is never asserted outside LOAD.

Optional Feature:
- Macro: JTDSP16_ROMVFY_EN.
- When defined, LOAD is followed by VERIFY instead of going directly to HOLD. The core stays in reset during VERIFY.
- VERIFY behaviour:
  - Drive pt = 0, 1, … for ceil(len/2) words.
  - Sum pt_dout bytes, accounting for the one-cycle read latency. If len is odd, sum only the LSB of the last word.
  - Compare the total with cks. On mismatch set vfy_err = 1, which stays set until the next start.
  - HOLD then proceeds regardless of the result.
- When not defined: pt = 0, vfy_err = 0, pt_dout is ignored, and there is no VERIFY state.

Test Plan:
- Reset, then start with dl_len = 4 and bytes 0x12, 0x34, 0x56, 0x78 with continuous dl_valid:
  - prog_we is high for 4 consecutive cycles with addr 0..3 and data in order.
  - cks = 0x0114.
  - dsp_rst falls RST_HOLD cycles after the last write, with a one-cycle done pulse.
- dl_len = 3 with dl_valid toggling every other cycle:
  - exactly 3 writes at addr 0, 1, 2, each one cycle after its handshake.
  - a 4th valid byte is never accepted (dl_ready = 0).
- dl_len = 0 with 8192 bytes of value 0x01:
  - last write at prog_addr = 0x1FFF.
  - cks = 0x2000.
  - busy stays high throughout the load.
- rstn asserted after 2 of 4 bytes:
  - all outputs return to reset values immediately, dsp_rst = 1.
  - a new start with dl_len = 2 writes addr 0 and 1.
- start pulsed during LOAD and during HOLD: no effect on counters or state.
- With JTDSP16_ROMVFY_EN and a ROM model:
  - a clean load of 4 bytes gives vfy_err = 0, and pt sequences 0, 1.
  - forcing pt_dout word 1 to 0x0000 gives vfy_err = 1, and dsp_rst is still released.

Source files
------------

// File: rtl/jtdsp16_rom_loader_if.sv
// jtdsp16_rom_loader_if: host download, ROM program/read-back and core control bundle of the ROM loader
interface jtdsp16_rom_loader_if;
    logic        start;
    logic [12:0] dl_len;
    logic [7:0]  dl_data;
    logic        dl_valid;
    logic        dl_ready;
    logic [12:0] prog_addr;
    logic [7:0]  prog_data;
    logic        prog_we;
    logic        dsp_rst;
    logic        busy;
    logic        done;
    logic [15:0] cks;
    logic [11:0] pt;
    logic [15:0] pt_dout;
    logic        vfy_err;
    modport master (
        input  start, dl_len, dl_data, dl_valid, pt_dout,
        output dl_ready, prog_addr, prog_data, prog_we, dsp_rst, busy, done, cks, pt, vfy_err
    );
    modport slave (
        output start, dl_len, dl_data, dl_valid, pt_dout,
        input  dl_ready, prog_addr, prog_data, prog_we, dsp_rst, busy, done, cks, pt, vfy_err
    );
endinterface

// File: rtl/jtdsp16_rom_loader.sv
// jtdsp16_rom_loader: programs the DSP16 internal ROM from a host byte stream while holding the core in reset.
// Define JTDSP16_ROMVFY_EN to read the ROM back after loading and flag a byte-sum mismatch on vfy_err.
module jtdsp16_rom_loader #(
    parameter int RST_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    jtdsp16_rom_loader_if.master bus
);
`ifdef JTDSP16_ROMVFY_EN
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
`endif
    state_t        r_st;
    logic [13:0]   r_rem;
    logic [12:0]   r_idx;
    logic [12:0]   r_addr;
    logic [7:0]    r_data;
    logic [15:0]   r_cks;
    logic [CW-1:0] r_hold;
    logic          r_ready;
    logic          r_we;
    logic          r_rst;
    logic          r_busy;
    logic          r_done;
    logic [13:0]   w_len;
    logic          w_acc;
    // a zero length selects the full 8 KB image
    assign w_len = (bus.dl_len == 13'd0) ? 14'h2000 : {1'b0, bus.dl_len};
    assign w_acc = r_ready & bus.dl_valid;
`ifdef JTDSP16_ROMVFY_EN
    logic [12:0] r_nw;
    logic [12:0] r_vc;
    logic [11:0] r_pt;
    logic [15:0] r_vsum;
    logic        r_odd;
    logic        r_err;
    logic [13:0] w_len_p1;
    logic [15:0] w_vsum;
    logic        w_vend;
    assign w_len_p1 = w_len + 14'd1;
    assign w_vend   = r_vc == r_nw;
    // pt_dout lags pt by one cycle, so step r_vc holds the data of word r_vc-1
    assign w_vsum   = r_vsum + ((w_vend && r_odd) ? {8'h0, bus.pt_dout[7:0]}
                                                  : {8'h0, bus.pt_dout[7:0]} + {8'h0, bus.pt_dout[15:8]});
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_nw   <= '0;
            r_vc   <= '0;
            r_pt   <= '0;
            r_vsum <= '0;
            r_odd  <= 1'b0;
            r_err  <= 1'b0;
        end else if (r_st == IDLE && bus.start) begin
            r_nw   <= w_len_p1[13:1];
            r_odd  <= bus.dl_len[0];
            r_vc   <= '0;
            r_pt   <= '0;
            r_vsum <= '0;
            r_err  <= 1'b0;
        end else if (r_st == VERIFY) begin
            r_vsum <= (r_vc != 13'd0) ? w_vsum : r_vsum;
            r_err  <= r_err | (w_vend & (w_vsum != r_cks));
            r_vc   <= w_vend ? r_vc : r_vc + 13'd1;
            r_pt   <= (r_vc + 13'd1 < r_nw) ? r_pt + 12'd1 : r_pt;
        end
    end
    assign bus.pt      = r_pt;
    assign bus.vfy_err = r_err;
`else
    assign bus.pt      = '0;
    assign bus.vfy_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_st    <= IDLE;
            r_rem   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cks   <= '0;
            r_hold  <= '0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_rst   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_st)
                IDLE: if (bus.start) begin
                    r_rem   <= w_len;
                    r_idx   <= '0;
                    r_cks   <= '0;
                    r_hold  <= '0;
                    r_ready <= 1'b1;
                    r_rst   <= 1'b1;
                    r_busy  <= 1'b1;
                    r_st    <= LOAD;
                end
                LOAD: if (w_acc) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_idx;
                    r_data  <= bus.dl_data;
                    r_cks   <= r_cks + {8'h0, bus.dl_data};
                    r_idx   <= r_idx + 13'd1;
                    r_rem   <= r_rem - 14'd1;
                    r_ready <= r_rem != 14'd1;
                end else if (r_rem == 14'd0) begin
`ifdef JTDSP16_ROMVFY_EN
                    r_st <= VERIFY;
`else
                    r_st <= HOLD;
`endif
                end
`ifdef JTDSP16_ROMVFY_EN
                VERIFY: if (w_vend) r_st <= HOLD;
`endif
                HOLD: if (r_hold == CW'(RST_HOLD - 1)) begin
                    r_rst  <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_st   <= IDLE;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
                default: r_st <= IDLE;
            endcase
        end
    end
    assign bus.dl_ready  = r_ready;
    assign bus.prog_we   = r_we;
    assign bus.prog_addr = r_addr;
    assign bus.prog_data = r_data;
    assign bus.cks       = r_cks;
    assign bus.dsp_rst   = r_rst;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_jtdsp16_rom_loader.sv
// tb_jtdsp16_rom_loader: table of load vectors checked through a ROM-write scoreboard,
// plus reset, mid-load abort and ignored-start sequences; builds with or without JTDSP16_ROMVFY_EN.
module tb_jtdsp16_rom_loader;
    localparam int RST_HOLD = 16;
    typedef struct {
        int          len;
        int          base;
        int          step;
        bit          gap;
        bit          poke;
        bit          zap;
        logic [15:0] cks;
    } vec_t;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic zap  = 1'b0;
    logic [15:0] rom [4096];
    logic [20:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int last_we = 0;
    int pt_max = 0;
    vec_t vt [7];
    jtdsp16_rom_loader_if bus();
    jtdsp16_rom_loader #(.RST_HOLD(RST_HOLD), .CW(5)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.prog_we) begin
            if (bus.prog_addr[0]) rom[bus.prog_addr[12:1]][15:8] <= bus.prog_data;
            else rom[bus.prog_addr[12:1]][7:0] <= bus.prog_data;
        end
        bus.pt_dout <= (zap && bus.pt == 12'd1) ? 16'h0000 : rom[bus.pt];
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    // one clock: move to the next falling edge and score any ROM write seen there
    task automatic tick();
        logic [20:0] e;
        @(negedge clk);
        cyc++;
        if (int'(bus.pt) > pt_max) pt_max = int'(bus.pt);
        if (rstn && bus.prog_we) begin
            wr_cnt++;
            last_we = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", bus.prog_addr, bus.prog_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.prog_addr, e[20:8]);
                chk("wr_data", bus.prog_data, e[7:0]);
            end
            chk("busy_in_load", bus.busy, 1);
            chk("rst_in_load", bus.dsp_rst, 1);
        end
    endtask
    task automatic check_reset();
        chk("rst_dsp_rst", bus.dsp_rst, 1);
        chk("rst_dl_ready", bus.dl_ready, 0);
        chk("rst_prog_we", bus.prog_we, 0);
        chk("rst_prog_addr", bus.prog_addr, 0);
        chk("rst_prog_data", bus.prog_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cks", bus.cks, 0);
        chk("rst_pt", bus.pt, 0);
        chk("rst_vfy_err", bus.vfy_err, 0);
    endtask
    task automatic run_vec(input vec_t v);
        int nb, nw, i, cy, exp_delay;
        bit seen;
        logic [7:0] d;
        nb = (v.len == 0) ? 8192 : v.len;
        nw = (nb + 1) / 2;
        zap = v.zap;
        bus.dl_len = 13'(v.len);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.dl_len = 13'h1555;
        wr_cnt = 0;
        pt_max = 0;
        chk("busy_on_start", bus.busy, 1);
        chk("rst_on_start", bus.dsp_rst, 1);
        i = 0;
        cy = 0;
        while (i < nb && cy < 4 * nb + 20) begin
            d = 8'(v.base + v.step * i);
            bus.dl_valid = !(v.gap && (cy % 2 == 1));
            bus.dl_data = d;
            bus.start = v.poke && i == 2;
            bus.dl_len = 13'd7;
            if (bus.dl_valid && bus.dl_ready) begin
                exp_q.push_back({13'(i), d});
                i++;
            end
            tick();
            cy++;
        end
        chk("bytes_accepted", i, nb);
        for (int k = 0; k < 6; k++) begin
            bus.dl_valid = 1'b1;
            bus.dl_data = 8'hEE;
            bus.start = v.poke && k == 5;
            chk("no_extra_ready", bus.dl_ready, 0);
            tick();
        end
        bus.dl_valid = 1'b0;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20000 && !seen; k++) begin
            if (bus.done) seen = 1'b1;
            else tick();
        end
        chk("done_seen", seen, 1);
`ifdef JTDSP16_ROMVFY_EN
        exp_delay = RST_HOLD + 1 + nw + 1;
`else
        exp_delay = RST_HOLD + 1;
`endif
        chk("rst_delay", cyc - last_we, exp_delay);
        chk("rst_low_at_done", bus.dsp_rst, 0);
        chk("cks", bus.cks, v.cks);
        chk("write_count", wr_cnt, nb);
        chk("queue_empty", exp_q.size(), 0);
`ifdef JTDSP16_ROMVFY_EN
        chk("vfy_err", bus.vfy_err, v.zap);
        chk("pt_last", pt_max, nw - 1);
`else
        chk("vfy_err_off", bus.vfy_err, 0);
        chk("pt_off", pt_max, 0);
`endif
        tick();
        chk("done_pulse", bus.done, 0);
        chk("busy_after", bus.busy, 0);
        chk("rst_stays_low", bus.dsp_rst, 0);
        zap = 1'b0;
    endtask
    initial begin
        int i;
        vt[0] = '{4,   'h12, 'h22, 1'b0, 1'b0, 1'b0, 16'h0114};
        vt[1] = '{3,   'hA0, 'h01, 1'b1, 1'b0, 1'b0, 16'h01E3};
        vt[2] = '{5,   'hFF, 'h11, 1'b0, 1'b1, 1'b0, 16'h01A5};
        vt[3] = '{1,   'h80, 'h00, 1'b0, 1'b0, 1'b0, 16'h0080};
        vt[4] = '{4,   'h12, 'h22, 1'b0, 1'b0, 1'b1, 16'h0114};
        vt[5] = '{255, 'hFF, 'h00, 1'b1, 1'b0, 1'b0, 16'hFE01};
        vt[6] = '{0,   'h01, 'h00, 1'b0, 1'b0, 1'b0, 16'h2000};
        bus.start = 1'b0;
        bus.dl_valid = 1'b0;
        bus.dl_len = '0;
        bus.dl_data = '0;
        repeat (3) tick();
        check_reset();
        rstn = 1'b1;
        tick();
        check_reset();
        for (int n = 0; n < 7; n++) run_vec(vt[n]);
        bus.dl_len = 13'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wr_cnt = 0;
        i = 0;
        for (int k = 0; k < 20 && (i < 2 || exp_q.size() != 0); k++) begin
            bus.dl_valid = (i < 2);
            bus.dl_data = 8'(8'h12 + 8'h22 * i);
            if (bus.dl_valid && bus.dl_ready) begin
                exp_q.push_back({13'(i), bus.dl_data});
                i++;
            end
            tick();
        end
        bus.dl_valid = 1'b1;
        chk("abort_writes", wr_cnt, 2);
        chk("abort_busy", bus.busy, 1);
        #1 rstn = 1'b0;
        #1 check_reset();
        bus.dl_valid = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        run_vec('{2, 'h9A, 'h01, 1'b0, 1'b0, 1'b0, 16'h0135});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
